// File: rtl/load_replay_scheduler_pkg.sv
// Shared defines for the load replay path: reply reason fields, the replay
// reason encoding and the per-entry replay state.
package load_replay_scheduler_pkg;

  localparam int REPLY_REASON_W = 2;

  typedef enum logic [REPLY_REASON_W-1:0] {
    REASON_FAST = 2'b00,
    REASON_SLOW = 2'b01
  } replay_reason_e;

  typedef enum logic [1:0] {
    RS_IDLE      = 2'd0,
    RS_WAIT_FAST = 2'd1,
    RS_WAIT_SLOW = 2'd2,
    RS_READY     = 2'd3
  } replay_state_e;

endpackage

// File: rtl/load_replay_scheduler_replay_select.sv
// ReplaySelect: round-robin pick of up to PORTS ready entries starting at
// rr_ptr; grants fill ports 0..PORTS-1 in search order.
module replay_select #(
  parameter int ENTRIES = 8,
  parameter int PORTS   = 2,
  parameter int IW      = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]         ready_vec,
  input  logic [IW-1:0]              rr_ptr,
  output logic [PORTS-1:0]           grant_valid,
  output logic [PORTS-1:0][IW-1:0]   grant_idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;
  logic          placed;

  always_comb begin
    grant_valid = '0;
    grant_idx   = '0;
    sum         = '0;
    pos         = '0;
    placed      = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(ENTRIES)) sum = sum - (IW+1)'(ENTRIES);
      pos    = sum[IW-1:0];
      placed = 1'b0;
      if (ready_vec[pos]) begin
        for (int p = 0; p < PORTS; p++) begin
          if (!placed && !grant_valid[p]) begin
            grant_valid[p] = 1'b1;
            grant_idx[p]   = pos;
            placed         = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/load_replay_scheduler.sv
// Load replay scheduler: parks rejected loads per issue index, waits a fixed
// (fast) or bounded/woken (slow) delay, then requests reissue round-robin.
module load_replay_scheduler
  import load_replay_scheduler_pkg::*;
#(
  parameter int ENTRIES      = 8,
  parameter int PORTS        = 2,
  parameter int FAST_DELAY   = 1,
  parameter int SLOW_TIMEOUT = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PORTS-1:0]                       reply_en,
  input  logic [PORTS-1:0][$clog2(ENTRIES)-1:0]  reply_idx,
  input  logic [PORTS-1:0][REPLY_REASON_W-1:0]   reply_reason,
  input  logic                                   wake_en,
  input  logic                                   flush,
  output logic [PORTS-1:0]                       replay_valid,
  output logic [PORTS-1:0][$clog2(ENTRIES)-1:0]  replay_idx,
  input  logic [PORTS-1:0]                       replay_ready,
  output logic                                   busy
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(SLOW_TIMEOUT + 1);
  localparam logic [CW-1:0] FAST_CNT = CW'(FAST_DELAY);
  localparam logic [CW-1:0] SLOW_CNT = CW'(SLOW_TIMEOUT);

  replay_state_e      st_q  [ENTRIES];
  replay_state_e      st_d  [ENTRIES];
  logic [CW-1:0]      cnt_q [ENTRIES];
  logic [CW-1:0]      cnt_d [ENTRIES];
  logic [IW-1:0]      rr_q, rr_d;
  logic [ENTRIES-1:0] ready_vec;
  logic [PORTS-1:0]   hs;

  always_comb begin
    ready_vec = '0;
    busy      = 1'b0;
    for (int e = 0; e < ENTRIES; e++) begin
      ready_vec[e] = (st_q[e] == RS_READY);
      busy         = busy | (st_q[e] != RS_IDLE);
    end
  end

  replay_select #(.ENTRIES(ENTRIES), .PORTS(PORTS), .IW(IW)) u_select (
    .ready_vec   (ready_vec),
    .rr_ptr      (rr_q),
    .grant_valid (replay_valid),
    .grant_idx   (replay_idx)
  );

  // Handshake: an entry is consumed at the edge where replay_valid[p] and
  // replay_ready[p] are both high; otherwise it stays READY and re-competes.
  assign hs = replay_valid & replay_ready;

  // Priority, lowest to highest: countdown, wake, handshake, enqueue, flush.
  always_comb begin
    rr_d = rr_q;
    for (int e = 0; e < ENTRIES; e++) begin
      st_d[e]  = st_q[e];
      cnt_d[e] = cnt_q[e];
      if (st_q[e] == RS_WAIT_FAST || st_q[e] == RS_WAIT_SLOW) begin
        if (cnt_q[e] <= CW'(1)) begin
          st_d[e]  = RS_READY;
          cnt_d[e] = '0;
        end else begin
          cnt_d[e] = cnt_q[e] - CW'(1);
        end
      end
      if (wake_en && st_q[e] == RS_WAIT_SLOW) begin
        st_d[e]  = RS_READY;
        cnt_d[e] = '0;
      end
      for (int p = 0; p < PORTS; p++) begin
        if (hs[p] && replay_idx[p] == IW'(e)) begin
          st_d[e]  = RS_IDLE;
          cnt_d[e] = '0;
        end
      end
      // Descending so port 0 has the final say on a shared index.
      for (int p = PORTS - 1; p >= 0; p--) begin
        if (reply_en[p] && reply_idx[p] == IW'(e)) begin
          if (reply_reason[p] == REASON_FAST) begin
            st_d[e]  = RS_WAIT_FAST;
            cnt_d[e] = FAST_CNT;
          end else begin
            st_d[e]  = RS_WAIT_SLOW;
            cnt_d[e] = SLOW_CNT;
          end
        end
      end
      if (flush) begin
        st_d[e]  = RS_IDLE;
        cnt_d[e] = '0;
      end
    end
    for (int p = 0; p < PORTS; p++) begin
      if (hs[p] && !flush) begin
        rr_d = (replay_idx[p] == IW'(ENTRIES - 1)) ? '0 : replay_idx[p] + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        st_q[e]  <= RS_IDLE;
        cnt_q[e] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int e = 0; e < ENTRIES; e++) begin
        st_q[e]  <= st_d[e];
        cnt_q[e] <= cnt_d[e];
      end
    end
  end

endmodule

// File: doc/load_replay_scheduler.md
LOAD_REPLAY_SCHEDULER -- requirements
Module: load_replay_scheduler

Interface
REQ-001 SHALL have parameter ENTRIES, default 8: replay table depth, equal to the load issue bank size.
REQ-002 SHALL have parameter PORTS, default 2: reply ports and replay ports, equal to LOAD_PIPELINE.
REQ-003 SHALL have parameter FAST_DELAY, default 1: wait cycles for reason 2'b00.
REQ-004 SHALL have parameter SLOW_TIMEOUT, default 16: maximum wait cycles for the other reasons.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high. This clocking and reset is fixed.
REQ-006 SHALL have ports: reply_en  in  PORTS  reject pulse per port; reply_idx  in  PORTS x clog2(ENTRIES)  issue index; reply_reason  in  PORTS x 2  reject reason.
REQ-007 SHALL have ports: wake_en  in  1  store-data/refill wakeup pulse; flush  in  1  redirect flush.
REQ-008 SHALL have ports: replay_valid  out  PORTS  replay request; replay_idx  out  PORTS x clog2(ENTRIES)  issue index to reissue; replay_ready  in  PORTS  issue queue accepts.
REQ-009 SHALL have port: busy  out  1  any entry not IDLE.

Function
REQ-010 SHALL keep one entry per issue index, direct-mapped by reply_idx; each entry holds state IDLE/WAIT_FAST/WAIT_SLOW/READY and a counter of clog2(SLOW_TIMEOUT+1) bits.
REQ-011 SHALL, on reply_en[p], load the entry: reason 2'b00 -> WAIT_FAST with counter=FAST_DELAY; any other reason -> WAIT_SLOW with counter=SLOW_TIMEOUT.
REQ-012 SHALL decrement the counter of each WAIT entry every cycle and move the entry to READY at the edge where the counter is 1.
REQ-013 SHALL give this timing: a reply in cycle t -> replay_valid in cycle t+1+FAST_DELAY (fast) or at the latest t+1+SLOW_TIMEOUT (slow).
REQ-014 SHALL, on wake_en in cycle w, move every WAIT_SLOW entry not being enqueued in cycle w to READY, so replay_valid is seen in cycle w+1.
REQ-015 SHALL select up to PORTS READY entries per cycle in round-robin order starting at rr_ptr and assign them to replay ports 0..PORTS-1 in search order; replay_valid and replay_idx are combinational from registered state.
REQ-016 SHALL return an entry to IDLE at the edge where replay_valid[p] & replay_ready[p] for its port; a non-accepted entry stays READY and keeps its grant candidacy.
REQ-017 SHALL, after any handshake, advance rr_ptr to one past the highest-order accepted entry, modulo ENTRIES (wrap 7 -> 0); otherwise rr_ptr holds.
REQ-018 SHALL let port 0 win when both reply ports target the same index in one cycle.
REQ-019 SHALL let enqueue win when it hits the same entry as a handshake in the same cycle: the entry is re-armed, not IDLE.
REQ-020 SHALL let enqueue on a non-IDLE entry overwrite its state and counter.
REQ-021 SHALL, on flush, set all entries IDLE at that edge; flush beats enqueue, wake and handshake, so replay_valid=0 the next cycle.
REQ-022 SHALL drive busy = OR of (state != IDLE) across entries, from registered state.
REQ-023 SHALL never assert two replay ports with the same replay_idx.

Reset
REQ-024 SHALL, while rst=1, hold all entries IDLE, counters 0, rr_ptr 0, and replay_valid=0, replay_idx=0, busy=0 regardless of clock.
REQ-025 SHALL discard pending waits when reset is asserted mid-operation; no replay is issued after deassertion without a new reply.

Structure
REQ-026 SHALL place the ReplayState enum and the ReplayReason encoding (00 fast, 01 slow) in the shared defines package, next to the existing reply reason fields.
REQ-027 SHALL implement the round-robin pick of PORTS entries from an ENTRIES-bit ready vector as one sub-module, ReplaySelect.

Verification
REQ-028 SHALL cover this directed scenario: reply port0 idx 3, reason 00, cycle 10 -> replay_valid[0]=1, idx 3 in cycle 12; ready=1 -> busy=0 in cycle 13.
REQ-029 SHALL cover this directed scenario: reply idx 5, reason 01, cycle 0, no wake -> replay_valid first seen cycle 17; wake_en in cycle 4 instead -> valid in cycle 5.
REQ-030 SHALL cover this directed scenario: entries 1, 2 and 6 READY, rr_ptr 0, both ready -> ports carry 1 and 2, rr_ptr=3, then 6 granted on port 0 next cycle.
REQ-031 SHALL cover this directed scenario: both ports reply idx 4 in the same cycle (port0 reason 00, port1 reason 01) -> entry WAIT_FAST, replay after 2 cycles.
REQ-032 SHALL cover this directed scenario: flush together with reply idx 0 and wake_en -> all IDLE, busy=0 and replay_valid=0 the next cycle.
REQ-033 SHALL cover this directed scenario: rst pulse asserted asynchronously between edges while 3 entries wait -> outputs 0 immediately, no replay for 20 cycles after release.
